// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: one request in flight, sub-word stores by read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module load_store_unit #(
    parameter int MEM_WORDS = 256,
    parameter int RD_W      = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [31:0]     address,
    output logic [31:0]     writeData,
    input  logic [31:0]     readData,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_data,
    output logic [RD_W-1:0] resp_rd,
    output logic            resp_err,
    output logic            stall
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] merge_word;

    logic        misalign, out_of_range, req_err;
    logic [31:0] aligned_addr;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Error decode and low-bit forcing happen on the incoming request, before latching.
    always_comb begin
        misalign     = (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        out_of_range = req_addr[31:2] >= 30'(MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
        req_err      = (req_size == 2'b11) || out_of_range || misalign;
`else
        req_err      = (req_size == 2'b11) || out_of_range;
`endif
        aligned_addr = req_addr;
        if (req_size == 2'b01)
            aligned_addr[0] = 1'b0;
        else if (req_size == 2'b10)
            aligned_addr[1:0] = 2'b00;
    end

    always_comb begin
        load_byte = readData[{r_addr[1:0], 3'b000} +: 8];
        load_half = readData[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   load_val = {{24{~r_unsigned & load_byte[7]}}, load_byte};
            2'b01:   load_val = {{16{~r_unsigned & load_half[15]}}, load_half};
            default: load_val = readData;
        endcase
    end

    // Merge the store lane into the word captured during RMW_RD.
    always_comb begin
        merged = merge_word;
        case (r_size)
            2'b00:   merged[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
            2'b01:   merged[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
            default: merged = r_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            merge_word <= '0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    r_size     <= req_size;
                    r_unsigned <= req_unsigned;
                    r_addr     <= aligned_addr;
                    r_wdata    <= req_wdata;
                    resp_rd    <= req_rd;
                    resp_data  <= '0;
                    resp_err   <= req_err;
                    if (req_err)                state <= RESP;
                    else if (!req_write)        state <= LOAD;
                    else if (req_size == 2'b10) state <= WRITE;
                    else                        state <= RMW_RD;
                end
                LOAD: begin
                    resp_data <= load_val;
                    state     <= RESP;
                end
                RMW_RD: begin
                    merge_word <= readData;
                    state      <= WRITE;
                end
                WRITE: state <= RESP;
                RESP:  if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side outputs depend only on state and latched fields.
    always_comb begin
        MemRead    = (state == LOAD) || (state == RMW_RD);
        MemWrite   = (state == WRITE);
        address    = (MemRead || MemWrite) ? {r_addr[31:2], 2'b00} : '0;
        writeData  = MemWrite ? merged : '0;
        req_ready  = (state == IDLE);
        stall      = ~req_ready;
        resp_valid = (state == RESP);
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset-mid-RMW sequences, random vs model.
module tb_load_store_unit;
    localparam int MEM_WORDS = 256;

    logic        clk, reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        MemRead, MemWrite;
    logic [31:0] address, writeData, readData;
    logic        resp_valid, resp_ready, resp_err, stall;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int checks = 0;
    int failures = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .RD_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
        .writeData(writeData), .readData(readData),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err), .stall(stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data_Memory stand-in: combinational read, write on rising edge.
    assign readData = mem[address[9:2]];
    always @(posedge clk)
        if (MemWrite) mem[address[9:2]] <= writeData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the access rules, on a plain word array.
    task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] d, output logic e, output int lat,
                         output logic mr, output logic mw);
        int idx, sh;
        bit trap, mis;
        logic [31:0] w, v, mask;
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = 1'b1;
`endif
        idx = int'(a >> 2);
        mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        e   = (sz == 2'd3) || (a >= 32'(MEM_WORDS * 4)) || (trap && mis);
        d = '0; mr = 1'b0; mw = 1'b0; lat = 1;
        if (!e) begin
            w  = ref_mem[idx];
            sh = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
            mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
            if (!wr) begin
                mr = 1'b1; lat = 2;
                if (sz == 2'd2) v = w;
                else begin
                    v = (w >> sh) & mask;
                    if (!uns && sz == 2'd0 && v >= 32'h80)   v = v | 32'hFFFFFF00;
                    if (!uns && sz == 2'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
                end
                d = v;
            end else if (sz == 2'd2) begin
                mw = 1'b1; lat = 2;
                ref_mem[idx] = wd;
            end else begin
                mr = 1'b1; mw = 1'b1; lat = 3;
                ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
            end
        end
    endtask

    task automatic xact(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int hold, input logic [31:0] e_data, input logic e_err,
                        input int e_lat, input logic e_mr, input logic e_mw, input string tag);
        int lat;
        logic saw_r, saw_w, both;
        @(negedge clk);
        chkb({tag, ".req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_rd = rd; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom();
        lat = 1; saw_r = 1'b0; saw_w = 1'b0; both = 1'b0;
        while (!resp_valid && lat < 10) begin
            saw_r |= MemRead; saw_w |= MemWrite; both |= MemRead & MemWrite;
            @(negedge clk);
            lat++;
        end
        chki({tag, ".latency"}, lat, e_lat);
        chkb({tag, ".resp_valid"}, resp_valid, 1'b1);
        chk ({tag, ".resp_data"}, resp_data, e_data);
        chkb({tag, ".resp_err"}, resp_err, e_err);
        chk ({tag, ".resp_rd"}, 32'(resp_rd), 32'(rd));
        chkb({tag, ".mem_read_seen"}, saw_r, e_mr);
        chkb({tag, ".mem_write_seen"}, saw_w, e_mw);
        chkb({tag, ".rd_wr_overlap"}, both, 1'b0);
        chkb({tag, ".resp_mem_idle"}, MemRead | MemWrite, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chkb({tag, ".hold_valid"}, resp_valid, 1'b1);
            chk ({tag, ".hold_data"}, resp_data, e_data);
            chkb({tag, ".hold_err"}, resp_err, e_err);
            chk ({tag, ".hold_rd"}, 32'(resp_rd), 32'(rd));
            chkb({tag, ".hold_req_ready"}, req_ready, 1'b0);
            chkb({tag, ".hold_stall"}, stall, 1'b1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chkb({tag, ".after_valid"}, resp_valid, 1'b0);
        chkb({tag, ".after_ready"}, req_ready, 1'b1);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] e_data;
        logic        e_err;
        int          e_lat;
        logic        e_mr;
        logic        e_mw;
    } vec_t;

    vec_t tbl[19];

    // Start a byte store to word 8 and pull reset during the given post-accept cycle.
    task automatic reset_mid_rmw(input int cycle, input string tag);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h000000AA; req_rd = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c < cycle; c++) @(negedge clk);
        chkb({tag, ".pre_memwrite"}, MemWrite, (cycle == 2));
        reset = 1'b1;
        #1;
        chkb({tag, ".memwrite"}, MemWrite, 1'b0);
        chkb({tag, ".memread"}, MemRead, 1'b0);
        chkb({tag, ".req_ready"}, req_ready, 1'b1);
        chkb({tag, ".stall"}, stall, 1'b0);
        chkb({tag, ".resp_valid"}, resp_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk({tag, ".mem_word"}, mem[8], 32'h11223344);
    endtask

    initial begin
        logic [31:0] d;
        logic e, mr, mw;
        int lat, mism;
        bit trap;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = 1'b1;
`endif
        //           wr  sz    uns  addr          wdata        hold data          err lat mr mw
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0, 2, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        5, 32'hDEADBEEF, 1'b0, 2, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h12,  32'hAAAAAA55, 0, 32'h0,        1'b0, 3, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        0, 32'hDE55BEEF, 1'b0, 2, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        0, 32'hFFFFFFDE, 1'b0, 2, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        1, 32'h000000DE, 1'b0, 2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        0, 32'hFFFFDE55, 1'b0, 2, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        0, 32'h0000BEEF, 1'b0, 2, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        0, 32'h0,        1'b1, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        2, 32'h0,        1'b1, 1, 1'b0, 1'b0};
        if (trap)
            tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,     0, 32'h0,        1'b1, 1, 1'b0, 1'b0};
        else
            tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,     0, 32'hFFFFBEEF, 1'b0, 2, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h16,  32'hFFFF1234, 0, 32'h0,        1'b0, 3, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        0, 32'h12340000, 1'b0, 2, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 2'd0, 1'b0, 32'h3FF, 32'h00000080, 0, 32'h0,        1'b0, 3, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h3FF, 32'h0,        0, 32'hFFFFFF80, 1'b0, 2, 1'b1, 1'b0};
        if (trap) begin
            tbl[15] = '{1'b1, 2'd2, 1'b0, 32'h21, 32'hCAFEF00D, 0, 32'h0,     1'b1, 1, 1'b0, 1'b0};
            tbl[16] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        0, 32'h0,     1'b0, 2, 1'b1, 1'b0};
        end else begin
            tbl[15] = '{1'b1, 2'd2, 1'b0, 32'h21, 32'hCAFEF00D, 0, 32'h0,     1'b0, 2, 1'b0, 1'b1};
            tbl[16] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        0, 32'hCAFEF00D, 1'b0, 2, 1'b1, 1'b0};
        end
        tbl[17] = '{1'b1, 2'd0, 1'b0, 32'h404, 32'h000000FF, 0, 32'h0,        1'b1, 1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 2'd2, 1'b1, 32'h3FC, 32'h0,        0, 32'h80000000, 1'b0, 2, 1'b1, 1'b0};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chkb("rst.req_ready", req_ready, 1'b1);
        chkb("rst.stall", stall, 1'b0);
        chkb("rst.memread", MemRead, 1'b0);
        chkb("rst.memwrite", MemWrite, 1'b0);
        chk ("rst.address", address, 32'h0);
        chk ("rst.writedata", writeData, 32'h0);
        chkb("rst.resp_valid", resp_valid, 1'b0);
        chk ("rst.resp_data", resp_data, 32'h0);
        chk ("rst.resp_rd", 32'(resp_rd), 32'h0);
        chkb("rst.resp_err", resp_err, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            // keep the reference memory in step; table constants are the expectations here
            model(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, d, e, lat, mr, mw);
            xact(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, 5'(i + 1),
                 tbl[i].hold, tbl[i].e_data, tbl[i].e_err, tbl[i].e_lat, tbl[i].e_mr,
                 tbl[i].e_mw, $sformatf("vec%0d", i));
        end

        model(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, d, e, lat, mr, mw);
        xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 5'd3, 0, d, e, lat, mr, mw, "seed_w8");
        reset_mid_rmw(1, "rst_rmw_rd");
        reset_mid_rmw(2, "rst_write");

        for (int n = 0; n < 250; n++) begin
            logic        wr, uns;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            wr  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 4095)
                                              : 32'($urandom_range(0, 127));
            wd  = $urandom();
            model(wr, sz, uns, a, wd, d, e, lat, mr, mw);
            xact(wr, sz, uns, a, wd, 5'($urandom_range(0, 31)), $urandom_range(0, 2),
                 d, e, lat, mr, mw, $sformatf("rnd%0d", n));
        end

        mism = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        chki("mem_final_mismatch_words", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
